// File: rtl/mul_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mul_ctrl_pkg
// Shared definitions for the radix-4 Booth multiplier controller:
//   - DATA_W_DEFAULT : default operand width
//   - state_t        : controller FSM states
//   - booth_t        : recoded radix-4 Booth digit
//   - booth_decode() : maps a multiplier bit triplet {b[2n+1], b[2n], b[2n-1]}
//                      onto a Booth digit
// ----------------------------------------------------------------------------
package mul_ctrl_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_POS1 = 3'd1,
    BD_POS2 = 3'd2,
    BD_NEG1 = 3'd3,
    BD_NEG2 = 3'd4
  } booth_t;

  function automatic booth_t booth_decode(input logic [2:0] triplet);
    booth_t digit;
    case (triplet)
      3'b001, 3'b010: digit = BD_POS1;
      3'b011:         digit = BD_POS2;
      3'b100:         digit = BD_NEG2;
      3'b101, 3'b110: digit = BD_NEG1;
      default:        digit = BD_ZERO;  // 000 and 111
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// ----------------------------------------------------------------------------
// mul_ctrl_if
// Request/response bundle of the multiplier controller.
//   start, flush : request a multiply / abort the running one
//   Mplr, Mcnd   : signed multiplier / multiplicand
//   busy, done   : operation running / one-cycle completion pulse
//   HI, LO       : upper / lower half of the last completed product
// Modports: master (requester side), slave (mul_ctrl side).
// ----------------------------------------------------------------------------
interface mul_ctrl_if #(
  parameter int DATA_W = 32
);

  logic              start;
  logic              flush;
  logic [DATA_W-1:0] Mplr;
  logic [DATA_W-1:0] Mcnd;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output start, flush, Mplr, Mcnd,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, flush, Mplr, Mcnd,
    output busy, done, HI, LO
  );

endinterface

// File: rtl/booth_r4_step.sv
// ----------------------------------------------------------------------------
// booth_r4_step
// Combinational radix-4 Booth step: recodes one multiplier triplet and adds
// the selected partial product {0, +/-M, +/-2M} to the accumulator.
//   triplet  : multiplier bits {b[2n+1], b[2n], b[2n-1]}
//   mcnd     : multiplicand, sign-extended and pre-shifted to weight 4^n
//   acc      : running sum
//   acc_next : acc + digit * mcnd
// ----------------------------------------------------------------------------
module booth_r4_step
  import mul_ctrl_pkg::*;
#(
  parameter int ACC_W = 66
) (
  input  logic [2:0]       triplet,
  input  logic [ACC_W-1:0] mcnd,
  input  logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] acc_next
);

  always_comb begin
    // NOTE: default assigned first so every path drives acc_next (no latch).
    acc_next = acc;
    case (booth_decode(triplet))
      BD_POS1: acc_next = acc + mcnd;
      BD_POS2: acc_next = acc + (mcnd << 1);
      BD_NEG1: acc_next = acc - mcnd;
      BD_NEG2: acc_next = acc - (mcnd << 1);
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/mul_ctrl.sv
// ----------------------------------------------------------------------------
// mul_ctrl
// Sequential signed multiplier, one radix-4 Booth digit per RUN cycle.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : mul_ctrl_if.slave (start/flush/Mplr/Mcnd in, busy/done/HI/LO out)
// Optional feature macro: MUL_EARLY_TERM_EN -- finish as soon as the
// remaining multiplier bits are all equal (all further digits are zero).
// Without it the latency is always DATA_W/2 RUN cycles.
// ----------------------------------------------------------------------------
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  mul_ctrl_if.slave  bus
);

  localparam int ACC_W = 2*DATA_W + 2;
  localparam int STEPS = DATA_W / 2;
  localparam int CNT_W = $clog2(STEPS) + 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  // Multiplier with the implicit bit -1 appended; shifted right two bits per
  // step so the current triplet always sits at [2:0].
  logic [DATA_W:0]    m_q, m_next;
  // Multiplicand sign-extended and shifted left two bits per step.
  logic [ACC_W-1:0]   mcnd_q;
  logic [ACC_W-1:0]   acc_q, acc_next;
  logic               accept, last_step, fin;

  assign accept    = (state_q != RUN) && bus.start;
  assign last_step = (cnt_q == CNT_W'(STEPS - 1));
  assign m_next    = {{2{m_q[DATA_W]}}, m_q[DATA_W:2]};

`ifdef MUL_EARLY_TERM_EN
  // Remaining bits uniform -> every later digit is zero; acc is already final.
  assign fin = last_step || (m_next == '0) || (m_next == '1);
`else
  assign fin = last_step;
`endif

  booth_r4_step #(.ACC_W(ACC_W)) u_step (
    .triplet  (m_q[2:0]),
    .mcnd     (mcnd_q),
    .acc      (acc_q),
    .acc_next (acc_next)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Flush only acts in RUN, where start is ignored anyway, so it always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN: begin
        if (bus.flush)  state_d = IDLE;
        else if (fin)   state_d = DONE;
      end
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand/accumulator registers are reset too, so a fresh power-up or
  // an aborted run never leaves stale data observable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      m_q    <= '0;
      mcnd_q <= '0;
      acc_q  <= '0;
      bus.HI <= '0;
      bus.LO <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      m_q    <= {bus.Mplr, 1'b0};
      mcnd_q <= {{(DATA_W+2){bus.Mcnd[DATA_W-1]}}, bus.Mcnd};
      acc_q  <= '0;
    end else if (state_q == RUN && !bus.flush) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      m_q    <= m_next;
      mcnd_q <= mcnd_q << 2;
      acc_q  <= acc_next;
      if (fin) {bus.HI, bus.LO} <= acc_next[2*DATA_W-1:0];
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_mul_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mul_ctrl
// Self-checking bench for mul_ctrl (DATA_W = 32). A behavioural model
// (plain signed multiply plus a latency countdown) is compared against the
// DUT every cycle; directed cases pin the model with literal products and
// latencies. Honours MUL_EARLY_TERM_EN when defined.
// ----------------------------------------------------------------------------
module tb_mul_ctrl;

  localparam int W = 32;
`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  mul_ctrl_if #(.DATA_W(W)) bus ();

  mul_ctrl #(.DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return sa * sb;
  endfunction

  // Cycles from accept to done: W/2, or with early termination the first
  // n >= 1 for which multiplier bits [31:2n-1] are all equal.
  function automatic int exp_lat(input logic [31:0] a);
    logic signed [31:0] s;
    if (EARLY) begin
      for (int n = 1; n < W/2; n++) begin
        s = $signed(a) >>> (2*n - 1);
        if (s == 0 || s == -1) return n;
      end
    end
    return W/2;
  endfunction

  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_out  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_run  = 1'b0;
      m_done = 1'b0;
      m_out  = '0;
    end else if (m_run) begin
      if (bus.flush) m_run = 1'b0;
      else if (m_left == 1) begin
        m_run  = 1'b0;
        m_done = 1'b1;
        m_out  = m_prod;
      end else m_left--;
    end else begin
      m_done = 1'b0;
      if (bus.start) begin
        m_run  = 1'b1;
        m_left = exp_lat(bus.Mplr);
        m_prod = smul(bus.Mplr, bus.Mcnd);
      end
    end
  end

  // Per-cycle comparison, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    check("busy",    {63'b0, bus.busy}, {63'b0, m_run});
    check("done",    {63'b0, bus.done}, {63'b0, m_done});
    check("product", {bus.HI, bus.LO},  m_out);
  end

  // ---------------- directed helpers ----------------
  // Issues one operation; lat = edges from accept until done is seen.
  // poke_at > 0 pulses start with different operands at that RUN cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.Mplr  = a;
    bus.Mcnd  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == poke_at) begin
        bus.start = 1'b1;
        bus.Mplr  = ~a;
        bus.Mcnd  = a ^ b;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) break;
    end
  endtask

  task automatic expect_no_done(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    check(name, {63'b0, seen}, 64'd0);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return {{24{r[7]}}, r[7:0]};
      1:       return {{16{r[15]}}, r[15:0]};
      2:       return (r[0]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      default: return r;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.Mplr  = '0;
    bus.Mcnd  = '0;

    repeat (3) @(negedge clk);
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_done", {63'b0, bus.done}, 64'd0);
    check("reset_hilo", {bus.HI, bus.LO},  64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_op(32'h0000_000F, 32'h0000_000A, 0, lat);
    check("p15x10_hilo", {bus.HI, bus.LO}, 64'h0000_0000_0000_0096);
    check("p15x10_lat",  64'(lat), EARLY ? 64'd3 : 64'd16);

    run_op(32'h0000_000F, 32'hFFFF_FFF6, 0, lat);
    check("p15xm10_hilo", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FF6A);
    check("p15xm10_lat",  64'(lat), EARLY ? 64'd3 : 64'd16);

    run_op(32'hFFFF_FFF1, 32'hFFFF_FFF6, 0, lat);
    check("m15xm10_hilo", {bus.HI, bus.LO}, 64'h0000_0000_0000_0096);
    check("m15xm10_lat",  64'(lat), EARLY ? 64'd3 : 64'd16);

    run_op(32'h0000_0000, 32'h0000_000A, 0, lat);
    check("zero_hilo", {bus.HI, bus.LO}, 64'd0);
    check("zero_lat",  64'(lat), EARLY ? 64'd1 : 64'd16);

    run_op(32'h8000_0000, 32'h8000_0000, 6, lat);
    check("minsq_hilo", {bus.HI, bus.LO}, 64'h4000_0000_0000_0000);
    check("minsq_lat",  64'(lat), 64'd16);

    // Flush after five steps: no done, previous product retained.
    @(negedge clk);
    bus.start = 1'b1;
    bus.Mplr  = 32'h1234_5678;
    bus.Mcnd  = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("flush_busy_before", {63'b0, bus.busy}, 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy_after", {63'b0, bus.busy}, 64'd0);
    expect_no_done("flush_no_done", 20);
    check("flush_hilo_kept", {bus.HI, bus.LO}, 64'h4000_0000_0000_0000);

    // Reset mid-run: asynchronous clear, no done pulse afterwards.
    @(negedge clk);
    bus.start = 1'b1;
    bus.Mplr  = 32'h7FFF_1234;
    bus.Mcnd  = 32'h0000_0077;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_hilo", {bus.HI, bus.LO},  64'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_no_done("rst_no_done", 20);

    // Randomized traffic: starts (also mid-run), occasional flush and reset.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.Mplr  = rand_op();
      bus.Mcnd  = rand_op();
      bus.flush = m_run && ($urandom_range(0, 23) == 0);
      reset     = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    reset     = 1'b0;
    repeat (25) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand width (even, >=4); product is 2*DATA_W.
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  request a signed multiply; sampled only while busy=0.
REQ-005 SHALL have port: flush  in  1  synchronous abort of an operation in progress.
REQ-006 SHALL have port: Mplr  in  DATA_W  signed multiplier, latched on accepted start.
REQ-007 SHALL have port: Mcnd  in  DATA_W  signed multiplicand, latched on accepted start.
REQ-008 SHALL have port: busy  out  1  high while in RUN.
REQ-009 SHALL have port: done  out  1  one-cycle pulse; HI/LO valid from this cycle.
REQ-010 SHALL have port: HI  out  DATA_W  upper half of the last completed product.
REQ-011 SHALL have port: LO  out  DATA_W  lower half of the last completed product.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE, latching Mplr/Mcnd and entering RUN with step count 0 on the same edge.
REQ-014 SHALL ignore start while in RUN; operands SHALL NOT be relatched.
REQ-015 SHALL retire one radix-4 Booth digit per RUN cycle using multiplier bits [2n+1:2n-1], with bit -1 = 0.
REQ-016 SHALL select a partial product in {0, +/-Mcnd, +/-2*Mcnd}, sign-extended to 2*DATA_W+2 bits before accumulation.
REQ-017 SHALL take exactly DATA_W/2 RUN cycles (16 for DATA_W=32) when early termination is not compiled in.
REQ-018 SHALL, on the edge that completes the final step, write {HI,LO} with the exact two's-complement product, move to DONE, and drive busy=0.
REQ-019 SHALL assert done only in DONE (exactly one cycle), then return to IDLE unless a start is accepted on that edge.
REQ-020 SHALL support back-to-back operation: start sampled in DONE re-enters RUN with no IDLE cycle.
REQ-021 SHALL, when flush=1 in RUN, return to IDLE on that edge with no done pulse and HI/LO unchanged.
REQ-022 SHALL give flush priority over start when both are high in the same cycle; flush in IDLE/DONE SHALL have no effect.
REQ-023 SHALL hold HI/LO stable except on the completing edge.

Reset
REQ-024 SHALL, on reset, asynchronously force state=IDLE, step count=0, busy=0, done=0, HI=0, LO=0 and clear the operand/accumulator registers.
REQ-025 SHALL, on reset during RUN, abandon the operation with no done pulse.

Configuration
REQ-026 SHALL recognise macro MUL_EARLY_TERM_EN.
REQ-027 SHALL, with MUL_EARLY_TERM_EN defined, complete after step n (n>=1) as soon as Mplr[DATA_W-1:2n-1] are all equal, applying the remaining shift so the product is unchanged.
REQ-028 SHALL, without MUL_EARLY_TERM_EN, always use the fixed DATA_W/2-cycle latency; all other behaviour SHALL be identical in both builds.

Structure
REQ-029 SHALL place the state enum, the Booth digit encoding and the DATA_W default in shared package mul_ctrl_pkg.
REQ-030 SHALL use one combinational sub-module, booth_r4_step, for digit recode and partial-product add/sub; the FSM, counter and registers SHALL stay in mul_ctrl.

Verification
REQ-031 SHALL cover: Mplr=0x0000000F, Mcnd=0x0000000A -> HI=0x00000000, LO=0x00000096; done 16 cycles after accept (3 with MUL_EARLY_TERM_EN).
REQ-032 SHALL cover: Mplr=0x0000000F, Mcnd=0xFFFFFFF6 -> HI=0xFFFFFFFF, LO=0xFFFFFF6A.
REQ-033 SHALL cover: Mplr=0xFFFFFFF1, Mcnd=0xFFFFFFF6 -> HI=0x00000000, LO=0x00000096; 3 RUN cycles with early termination.
REQ-034 SHALL cover: Mplr=0, Mcnd=0x0000000A -> HI=LO=0; 1 RUN cycle with early termination.
REQ-035 SHALL cover: Mplr=Mcnd=0x80000000 -> HI=0x40000000, LO=0; a start pulsed mid-RUN is ignored.
REQ-036 SHALL cover: flush at step 5, then reset asserted mid-RUN -> no done pulse; HI/LO keep the prior value after flush and read 0 after reset.
